logic_unit_seq: RTL and testbench

Parametrised, sequential successor to the 8-bit combinational inverter in the ALU logic path. It performs one of eight bitwise operations on two WIDTH-bit operands, CHUNK bits per cycle, LSB chunk first, and returns the result with zero, parity and ones-count flags. It uses valid/ready handshakes on both sides. It sits between the ALU operand registers and the result/flag writeback stage, so narrow-datapath builds can share a small logic slice across wide operands.

---
 rtl/logic_unit_seq.sv | 143 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: applies one of eight operations CHUNK bits per cycle,
// LSB chunk first, and returns the result with zero, parity and population-count flags.
module logic_unit_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             result,
    output logic                         zero,
    output logic                         parity,
    output logic [$clog2(WIDTH+1)-1:0]   ones
);

    localparam int unsigned BEATS  = WIDTH / CHUNK;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned ONES_W = $clog2(WIDTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("logic_unit_seq: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [2:0]          op_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [CHUNK-1:0]    chunk_a;
    logic [CHUNK-1:0]    chunk_b;
    logic [CHUNK-1:0]    chunk_res;
    logic [ONES_W-1:0]   ones_nxt;

    function automatic logic [CHUNK-1:0] apply_op(input logic [2:0]       o,
                                                  input logic [CHUNK-1:0] x,
                                                  input logic [CHUNK-1:0] y);
        case (o)
            3'b000:  apply_op = ~x;
            3'b001:  apply_op = x & y;
            3'b010:  apply_op = x | y;
            3'b011:  apply_op = x ^ y;
            3'b100:  apply_op = ~(x & y);
            3'b101:  apply_op = ~(x | y);
            3'b110:  apply_op = ~(x ^ y);
            default: apply_op = x;
        endcase
    endfunction

    function automatic logic [ONES_W-1:0] popcount(input logic [CHUNK-1:0] x);
        popcount = '0;
        for (int unsigned k = 0; k < CHUNK; k++) begin
            popcount = popcount + ONES_W'(x[k]);
        end
    endfunction

    // Select the current chunk of the latched operands and evaluate it.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat == BEAT_W'(k)) begin
                chunk_a = a_q[k*CHUNK +: CHUNK];
                chunk_b = b_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_res = apply_op(op_q, chunk_a, chunk_b);
        ones_nxt  = ones + popcount(chunk_res);
    end

    assign parity = ones[0];

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            beat      <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            ones      <= '0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= op;
                        a_q      <= a;
                        b_q      <= b;
                        beat     <= '0;
                        result   <= '0;
                        ones     <= '0;
                        zero     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int unsigned k = 0; k < BEATS; k++) begin
                        if (beat == BEAT_W'(k)) begin
                            result[k*CHUNK +: CHUNK] <= chunk_res;
                        end
                    end
                    ones <= ones_nxt;
                    zero <= (ones_nxt == '0);
                    beat <= beat + BEAT_W'(1);
                    if (beat == LAST_BEAT) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: whole-word reference model with per-cycle compare on the
// 8/2 instance, plus directed literal checks on both the 8/2 and 16/16 instances.
module tb_logic_unit_seq;

    localparam int unsigned BEATS8 = 4;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, zero, parity;
    logic [2:0]  op;
    logic [7:0]  a, b, result;
    logic [3:0]  ones;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_zero, w_parity;
    logic [2:0]  w_op;
    logic [15:0] w_a, w_b, w_result;
    logic [4:0]  w_ones;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_rdy, m_valid;
    int          m_cnt;
    logic [7:0]  m_res;
    int          m_ones;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .parity(parity), .ones(ones)
    );

    logic_unit_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
        .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
        .zero(w_zero), .parity(w_parity), .ones(w_ones)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    ref_op = ~x;
            3'd1:    ref_op = x & y;
            3'd2:    ref_op = x | y;
            3'd3:    ref_op = x ^ y;
            3'd4:    ref_op = ~(x & y);
            3'd5:    ref_op = ~(x | y);
            3'd6:    ref_op = ~(x ^ y);
            default: ref_op = x;
        endcase
    endfunction

    // Transaction-level model: a request takes BEATS8 cycles, then waits for the consumer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy   = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_rdy   = 1'b1;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1'b1;
        end else if (m_rdy && in_valid) begin
            m_res  = ref_op(op, a, b);
            m_ones = $countones(m_res);
            m_cnt  = BEATS8;
            m_rdy  = 1'b0;
        end else begin
            m_rdy = 1'b1;
        end
    end

    // Per-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'(0));
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_result", 32'(result), 32'(0));
            chk("rst_ones", 32'(ones), 32'(0));
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("result", 32'(result), 32'(m_res));
                chk("ones", 32'(ones), 32'(m_ones));
                chk("zero", 32'(zero), 32'(m_ones == 0));
                chk("parity", 32'(parity), 32'(m_ones % 2));
            end else if (m_cnt > 0) begin
                logic [31:0] mask;
                mask = (32'd1 << ((BEATS8 - m_cnt) * 2)) - 32'd1;
                chk("partial_result", 32'(result), 32'(m_res) & mask);
            end
        end
    end

    // One request on the 8-bit instance; optional literal expectations and consumer stall.
    task automatic xact(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input int hold, input bit pulse, input bit lit,
                        input logic [7:0] er, input int eo, input bit ep, input bit ez);
        int n;
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        a         = xa;
        b         = xb;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(in_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = pulse ? 8'($urandom) : 8'h00;
        b = pulse ? 8'($urandom) : 8'h00;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (pulse) begin
                in_valid = 1'($urandom);
                op       = 3'($urandom);
            end
        end
        if (lit) begin
            chk("latency", 32'(lat), 32'(BEATS8));
            chk("lit_result", 32'(result), 32'(er));
            chk("lit_ones", 32'(ones), 32'(eo));
            chk("lit_parity", 32'(parity), 32'(ep));
            chk("lit_zero", 32'(zero), 32'(ez));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (pulse) in_valid = 1'($urandom);
            chk("hold_in_ready", 32'(in_ready), 32'(0));
            if (lit) chk("hold_result", 32'(result), 32'(er));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_consume", 32'(in_ready), 32'(1));
        chk("valid_after_consume", 32'(out_valid), 32'(0));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        {in_valid, out_ready, op, a, b} = '0;
        {w_in_valid, w_out_ready, w_op, w_a, w_b} = '0;
        repeat (3) @(negedge clk);
        chk("w_rst_in_ready", 32'(w_in_ready), 32'(0));
        chk("w_rst_result", 32'(w_result), 32'(0));
        rst_n = 1'b1;
        #1 chk("ready_low_before_edge", 32'(in_ready), 32'(0));

        xact(3'b000, 8'd15, 8'h00, 0, 1'b0, 1'b1, 8'b1111_0000, 4, 1'b0, 1'b0);
        xact(3'b011, 8'hAA, 8'hAA, 0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1);
        xact(3'b000, 8'hAA, 8'h00, 0, 1'b0, 1'b1, 8'h55, 4, 1'b0, 1'b0);
        xact(3'b100, 8'hFF, 8'h0F, 3, 1'b1, 1'b1, 8'hF0, 4, 1'b0, 1'b0);
        xact(3'b001, 8'hF3, 8'h3F, 0, 1'b0, 1'b1, 8'h33, 4, 1'b0, 1'b0);

        // Reset in the middle of an operation
        @(negedge clk);
        in_valid = 1'b1; op = 3'b010; a = 8'h01; b = 8'h80; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'(0));
        chk("async_rst_result", 32'(result), 32'(0));
        chk("async_rst_ones", 32'(ones), 32'(0));
        chk("async_rst_in_ready", 32'(in_ready), 32'(0));
        chk("async_rst_w_in_ready", 32'(w_in_ready), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready_low", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1 chk("post_rst_ready_high", 32'(in_ready), 32'(1));
        xact(3'b111, 8'h07, 8'hC3, 0, 1'b0, 1'b1, 8'h07, 3, 1'b1, 1'b0);

        // Single-beat wide instance
        @(negedge clk);
        w_in_valid = 1'b1; w_op = 3'b101; w_a = 16'h0000; w_b = 16'h0001; w_out_ready = 1'b1;
        n = 0;
        while (!w_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        chk("w_busy_valid", 32'(w_out_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        chk("w_out_valid", 32'(w_out_valid), 32'(1));
        chk("w_result", 32'(w_result), 32'hFFFE);
        chk("w_ones", 32'(w_ones), 32'(15));
        chk("w_parity", 32'(w_parity), 32'(1));
        chk("w_zero", 32'(w_zero), 32'(0));
        @(posedge clk);
        @(negedge clk);
        chk("w_ready_after_consume", 32'(w_in_ready), 32'(1));

        // Randomized traffic checked by the model
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            xact(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), 1'b0, 8'h00, 0, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
